// File: rtl/filter3x3_pkg.sv
// Shared types and constants for the 3x3 filter MAC sequencer.
// Used by filter3x3_mac_seq and mac_unit.
package filter3x3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam int NUM_TAPS    = 9;
  localparam int PIXEL_WIDTH = 8;
  localparam int TAP_WIDTH   = 4;

endpackage

// File: rtl/filter3x3_mac_seq_mac.sv
// mac_unit: registered pixel*weight product plus combinational bias add.
// Pixel is an unsigned integer, weight/bias/result are signed fixed point.
import filter3x3_pkg::*;

module mac_unit #(
  parameter int FP_WORD_LENGTH = 32,
  parameter int FP_FRAC_LENGTH = 15,
  parameter int MAC_LATENCY    = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid,
  input  logic [PIXEL_WIDTH-1:0]    pixel,
  input  logic [FP_WORD_LENGTH-1:0] weight,
  input  logic [FP_WORD_LENGTH-1:0] bias,
  output logic [FP_WORD_LENGTH-1:0] result
);

  localparam int W  = FP_WORD_LENGTH;
  localparam int PW = 2 * W;

  logic signed [PW-1:0] px_fp;
  logic signed [PW-1:0] wt_ext;
  logic signed [PW-1:0] full;
  logic        [W-1:0]  prod;
  logic        [W-1:0]  pipe [MAC_LATENCY];

  // Pixel promoted to fixed point, product rescaled back to W bits (wraps).
  always_comb begin
    px_fp  = {{(PW-PIXEL_WIDTH){1'b0}}, pixel} <<< FP_FRAC_LENGTH;
    wt_ext = {{W{weight[W-1]}}, weight};
    full   = px_fp * wt_ext;
    prod   = W'(full >>> FP_FRAC_LENGTH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAC_LATENCY; i++) pipe[i] <= '0;
    end else begin
      if (valid) pipe[0] <= prod;
      for (int i = 1; i < MAC_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign result = pipe[MAC_LATENCY-1] + bias;

endmodule

// File: rtl/filter3x3_mac_seq.sv
// filter3x3_mac_seq: serial 3x3 convolution over one shared mac_unit.
// Optional FILTER3X3_RELU_EN clamps negative results to zero at output.
import filter3x3_pkg::*;

module filter3x3_mac_seq #(
  parameter int FP_WORD_LENGTH = 32,
  parameter int FP_FRAC_LENGTH = 15,
  parameter int MAC_LATENCY    = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_TAPS*PIXEL_WIDTH-1:0]    in_pixels,
  input  logic [NUM_TAPS*FP_WORD_LENGTH-1:0] cfg_weights,
  input  logic [FP_WORD_LENGTH-1:0]          cfg_bias,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [FP_WORD_LENGTH-1:0]          out_data,
  output logic                               busy
);

  localparam int W   = FP_WORD_LENGTH;
  localparam int WCW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  state_t               state;
  logic [TAP_WIDTH-1:0] tap;
  logic [WCW-1:0]       wcnt;
  logic [W-1:0]         acc;
  logic [PIXEL_WIDTH-1:0] pix_q [NUM_TAPS];
  logic [W-1:0]         wts_q [NUM_TAPS];
  logic                 mac_valid;
  logic [W-1:0]         mac_out;

  mac_unit #(
    .FP_WORD_LENGTH(FP_WORD_LENGTH),
    .FP_FRAC_LENGTH(FP_FRAC_LENGTH),
    .MAC_LATENCY   (MAC_LATENCY)
  ) u_mac (
    .clk    (clk),
    .reset_n(reset_n),
    .valid  (mac_valid),
    .pixel  (pix_q[tap]),
    .weight (wts_q[tap]),
    .bias   (acc),
    .result (mac_out)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tap       <= '0;
      wcnt      <= '0;
      acc       <= '0;
      mac_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        pix_q[i] <= '0;
        wts_q[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
              pix_q[i] <= in_pixels[PIXEL_WIDTH*i +: PIXEL_WIDTH];
              wts_q[i] <= cfg_weights[W*i +: W];
            end
            acc       <= cfg_bias;
            tap       <= '0;
            mac_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mac_valid <= 1'b0;
          wcnt      <= WCW'(MAC_LATENCY - 1);
          state     <= WAIT;
        end
        WAIT: begin
          if (wcnt == '0) begin
            acc <= mac_out;
            if (tap == TAP_WIDTH'(NUM_TAPS - 1)) begin
`ifdef FILTER3X3_RELU_EN
              out_data <= mac_out[W-1] ? '0 : mac_out;
`else
              out_data <= mac_out;
`endif
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              tap       <= tap + 1'b1;
              mac_valid <= 1'b1;
              state     <= ISSUE;
            end
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter3x3_mac_seq.sv
// Directed bench for filter3x3_mac_seq: latency, kernels, backpressure,
// config snapshot, negative result and mid-operation reset.
module tb_filter3x3_mac_seq;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [71:0]   in_pixels;
  logic [287:0]  cfg_weights;
  logic [31:0]   cfg_bias;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  filter3x3_mac_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixels  (in_pixels),
    .cfg_weights(cfg_weights),
    .cfg_bias   (cfg_bias),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] w, input logic [7:0] p,
                      input logic [31:0] b);
    for (int i = 0; i < 9; i++) begin
      in_pixels[8*i +: 8]     = p;
      cfg_weights[32*i +: 32] = w;
    end
    cfg_bias = b;
  endtask

  // Returns at #1 after the accepting edge (cycle 1 of the operation).
  task automatic accept(input string tag);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    if (!ok) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_out(input string tag, output int n);
    n = 1;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk({tag, "_out_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic consume(input string tag);
    @(posedge clk); #1;
    chk({tag, "_ov_clear"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    load(32'h0, 8'd0, 32'h0);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Uniform kernel: 9 * 10 * 1.0 = 90.0
    load(32'h0000_8000, 8'd10, 32'h0);
    accept("uni");
    in_valid = 1'b0;
    chk("uni_busy", {31'd0, busy}, 32'd1);
    wait_out("uni", lat);
    chk("uni_latency", lat, 32'd19);
    chk("uni_data", out_data, 32'h002D_0000);
    consume("uni");

    // Identity kernel: 200 * 1.0 + 2.0
    load(32'h0, 8'd255, 32'h0001_0000);
    in_pixels[39:32]   = 8'd200;
    cfg_weights[159:128] = 32'h0000_8000;
    accept("id");
    in_valid = 1'b0;
    wait_out("id", lat);
    chk("id_data", out_data, 32'h0065_0000);
    consume("id");

    // Config changed at cycle 5 must not affect the running window
    load(32'h0000_8000, 8'd10, 32'h0);
    accept("snap");
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 load(32'h0, 8'd0, 32'h0012_3456);
    wait_out("snap", lat);
    chk("snap_data", out_data, 32'h002D_0000);
    consume("snap");

    // Negative result: 9 * 1 * -1.0 = -9.0
    load(32'hFFFF_8000, 8'd1, 32'h0);
    accept("neg");
    in_valid = 1'b0;
    wait_out("neg", lat);
`ifdef FILTER3X3_RELU_EN
    chk("neg_data", out_data, 32'h0000_0000);
`else
    chk("neg_data", out_data, 32'hFFFB_8000);
`endif
    consume("neg");

    // Backpressure with a second window waiting
    out_ready = 1'b0;
    load(32'h0000_8000, 8'd10, 32'h0);
    accept("bp");
    load(32'h0, 8'd255, 32'h0001_0000);
    in_pixels[39:32]     = 8'd200;
    cfg_weights[159:128] = 32'h0000_8000;
    wait_out("bp", lat);
    chk("bp_latency", lat, 32'd19);
    chk("bp_data", out_data, 32'h002D_0000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", out_data, 32'h002D_0000);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_ov_clear", {31'd0, out_valid}, 32'd0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accept", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    wait_out("bp2", lat);
    chk("bp2_latency", lat, 32'd19);
    chk("bp2_data", out_data, 32'h0065_0000);
    consume("bp2");

    // Reset in the middle of an operation
    load(32'h0000_8000, 8'd10, 32'h0);
    accept("rst");
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("mid_rst_no_result", {31'd0, out_valid}, 32'd0);
    accept("post");
    in_valid = 1'b0;
    wait_out("post", lat);
    chk("post_rst_data", out_data, 32'h002D_0000);
    consume("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/filter3x3_mac_seq.md
Name: filter3x3_mac_seq

Overview:
- Sequences one shared `mac` instance through the nine taps of a 3x3 convolution window and produces one fixed-point filter result per window.
- Sits between the line-buffer/window generator upstream and the pixel output path downstream of the avalon_filter_3x3 datapath.
- Snapshots the kernel weights and bias at window accept, accumulates serially through the MAC bias input, and returns the result over a valid/ready handshake.

Parameters:
- FP_WORD_LENGTH, 32, fixed-point word width of weights, bias, accumulator and result.
- FP_FRAC_LENGTH, 15, fractional bits; passed through to the `mac` instance.
- MAC_LATENCY, 1, clock cycles from `mac` valid to a stable `mac` out (registered multiply).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  window present.
- in_ready  out  1  block can accept a window.
- in_pixels  in  72  nine 8-bit unsigned pixels; tap i is [8i+7:8i], row-major, i=0 is top-left.
- cfg_weights  in  9*FP_WORD_LENGTH  tap i weight is [FP_WORD_LENGTH*i +: FP_WORD_LENGTH].
- cfg_bias  in  FP_WORD_LENGTH  initial accumulator value.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  FP_WORD_LENGTH  filter result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE; in_ready=1; out_valid=0; out_data=0; busy=0.
  - Tap index, wait counter, accumulator and snapshot registers all cleared.
  - `mac` valid driven 0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_pixels, cfg_weights and cfg_bias.
  - acc<=cfg_bias, tap<=0, go to ISSUE.
  - cfg_* changes after accept do not affect the operation in progress.
- ISSUE, 1 cycle:
  - Drive `mac` with valid=1, in=pixel[tap], w=weight[tap], b=acc.
  - Go to WAIT with wcnt<=MAC_LATENCY-1.
- WAIT, MAC_LATENCY cycles:
  - `mac` valid=0.
  - in, w and b are held at the tap values; acc is unchanged, so the combinational add stays stable.
  - In the last WAIT cycle (wcnt==0): acc<=mac out.
  - If tap==8: out_data<=mac out, go to DONE. Otherwise tap<=tap+1, go to ISSUE.
- DONE:
  - out_valid=1; out_data held stable until accepted.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready=0 while in DONE; there is no overlap of result and next window.
- Latency:
  - Accept at edge E0; out_valid is high from cycle 9*(MAC_LATENCY+1)+1 after E0 (19 for MAC_LATENCY=1).
  - Minimum window period is that value plus 1 cycle.
- Arithmetic:
  - Each tap computes acc_next = acc + pixel*weight, in FP_WORD_LENGTH/FP_FRAC_LENGTH format.
  - Overflow follows `mac` (two's-complement wrap); the sequencer adds no extra saturation.
- busy = (state != IDLE).
- out_ready held high continuously: the result is accepted the first cycle out_valid is 1.
- out_ready asserted while out_valid=0: ignored.
- reset_n asserted mid-operation: operation aborted, no partial result emitted.

Optional Feature:
- Macro: FILTER3X3_RELU_EN.
- Defined: at the DONE load, if mac out bit FP_WORD_LENGTH-1 is 1, out_data<=0; otherwise out_data<=mac out. The accumulator itself is unclamped.
- Undefined: out_data<=mac out unmodified.

Decomposition:
- Shared package filter3x3_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE}.
  - NUM_TAPS=9, PIXEL_WIDTH=8.
  - Tap index width 4.
- One sub-module: the existing `mac` instance (mac_unit), parameterised with FP_WORD_LENGTH/FP_FRAC_LENGTH. The sequencer FSM, counters and snapshot registers live in filter3x3_mac_seq.

Test Plan:
- Uniform kernel:
  - Stimulus: all weights 0x00008000 (1.0), bias 0, all pixels 10, out_ready=1.
  - Required: out_data=0x002D0000 (90.0); out_valid rises exactly 19 cycles after accept.
- Identity kernel:
  - Stimulus: weight[4]=0x00008000, others 0, bias 0x00010000 (2.0), pixel[4]=200, others 255.
  - Required: out_data=0x00650000 (202.0).
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid, with in_valid held high and a new window waiting.
  - Required: out_data stable; in_ready=0 throughout. After the out_ready pulse: out_valid=0, in_ready=1 the next cycle, second window accepted.
- Config snapshot:
  - Stimulus: change cfg_weights to all 0 at cycle 5 of the uniform-kernel run.
  - Required: result still 0x002D0000.
- Negative result:
  - Stimulus: all weights 0xFFFF8000 (-1.0), pixels all 1, bias 0.
  - Required: out_data=0xFFFB8000 without FILTER3X3_RELU_EN; 0x00000000 with it.
- Reset mid-op:
  - Stimulus: reset_n low at cycle 7 after accept for 2 cycles.
  - Required: immediately out_valid=0, busy=0; after release in_ready=1. A following uniform-kernel window gives 0x002D0000.
